// File: rtl/alu_flag_unit.sv
// alu_flag_unit: registered per-lane carry/zero/sign/overflow flags for
// full-width or packed-lane ALU operations. The result is held in a one-entry
// valid/ready output stage, with sticky carry/overflow accumulators per lane.
module alu_flag_unit #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         opsel,
  input  logic               mode,
  input  logic [WIDTH-1:0]   op1,
  input  logic [WIDTH-1:0]   op2,
  input  logic [WIDTH-1:0]   result,
  input  logic [LANES-1:0]   cout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES-1:0]   c_flag,
  output logic [LANES-1:0]   z_flag,
  output logic [LANES-1:0]   o_flag,
  output logic [LANES-1:0]   s_flag,
  output logic [LANES-1:0]   sticky_c,
  output logic [LANES-1:0]   sticky_o,
  input  logic               sticky_clr
);

  localparam int unsigned LW = WIDTH / LANES;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL1 = 3'b101,
    OP_SHR1 = 3'b110,
    OP_CMP  = 3'b111
  } op_e;

  // Flags of one lane, packed as {c, z, s, o}.
  function automatic logic [3:0] lane_flags(
    input logic [2:0] op,
    input logic       a_msb,
    input logic       b_msb,
    input logic       r_msb,
    input logic       a_lsb,
    input logic       r_zero,
    input logic       carry
  );
    logic c;
    logic o;
    c = 1'b0;
    o = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        c = carry;
        o = (a_msb == b_msb) & (r_msb != a_msb);
      end
      OP_SUB, OP_CMP: begin
        c = ~carry;
        o = (a_msb != b_msb) & (r_msb != a_msb);
      end
      OP_SHL1: c = a_msb;
      OP_SHR1: c = a_lsb;
      default: begin
        c = 1'b0;
        o = 1'b0;
      end
    endcase
    return {c, r_zero, r_msb, o};
  endfunction

  logic             xfer_in;
  logic [LANES-1:0] pk_c, pk_z, pk_s, pk_o;
  logic             f_c, f_z, f_s, f_o;
  logic [LANES-1:0] new_c, new_z, new_s, new_o;

  assign in_ready = !out_valid | out_ready;
  assign xfer_in  = in_valid & in_ready;

  // Packed-lane flags, one evaluator per lane slice.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam int unsigned LO = g * LW;
    localparam int unsigned HI = g * LW + LW - 1;
    assign {pk_c[g], pk_z[g], pk_s[g], pk_o[g]} =
      lane_flags(opsel, op1[HI], op2[HI], result[HI], op1[LO],
                 (result[HI:LO] == '0), cout[g]);
  end

  // Full-width flags: the whole datapath is a single lane.
  assign {f_c, f_z, f_s, f_o} =
    lane_flags(opsel, op1[WIDTH-1], op2[WIDTH-1], result[WIDTH-1], op1[0],
               (result == '0), cout[LANES-1]);

  // Select packed or full flags; full mode reports only in bit 0.
  always_comb begin
    new_c = '0;
    new_z = '0;
    new_s = '0;
    new_o = '0;
    if (mode) begin
      new_c = pk_c;
      new_z = pk_z;
      new_s = pk_s;
      new_o = pk_o;
    end else begin
      new_c[0] = f_c;
      new_z[0] = f_z;
      new_s[0] = f_s;
      new_o[0] = f_o;
    end
  end

  // One-entry output stage: load on accept, drain on downstream ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      c_flag    <= '0;
      z_flag    <= '0;
      s_flag    <= '0;
      o_flag    <= '0;
    end else if (xfer_in) begin
      out_valid <= 1'b1;
      c_flag    <= new_c;
      z_flag    <= new_z;
      s_flag    <= new_s;
      o_flag    <= new_o;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky accumulators; flags of a coincident accept survive a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_c <= '0;
      sticky_o <= '0;
    end else begin
      sticky_c <= (sticky_clr ? '0 : sticky_c) | (xfer_in ? new_c : '0);
      sticky_o <= (sticky_clr ? '0 : sticky_o) | (xfer_in ? new_o : '0);
    end
  end

endmodule
